// File: rtl/seg7_scan_ctrl_if.sv
// Value-source / display-pin bundle for the multiplexed 7-segment scanner.
// master = value source and pin observer, slave = scan controller.
interface seg7_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);
  logic                  enable;
  logic                  load;
  logic [4*N_DIGITS-1:0] value;
  logic                  lz_en;
  logic [3:0]            digit_code;
  logic [N_DIGITS-1:0]   an;
  logic                  frame_start;

  modport master (
    output enable, load, value, lz_en,
    input  digit_code, an, frame_start
  );

  modport slave (
    input  enable, load, value, lz_en,
    output digit_code, an, frame_start
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Purpose: time-multiplexes one hex decoder over N_DIGITS common-anode digits, blanking at each switch.
// Latency: all outputs registered, one cycle after the deciding input/state edge.
// Backpressure: none; load is a fire-and-forget strobe, the last load before a frame boundary wins.
module seg7_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input logic            clk,
  input logic            rst,
  seg7_scan_ctrl_if.slave bus
);
  localparam int VW     = 4 * N_DIGITS;
  localparam int SLOT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W  = $clog2(REFRESH_DIV);

  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] DIGIT_LAST = SLOT_W'(N_DIGITS - 1);

  typedef enum logic [1:0] {OFF, BLANK, SHOW} state_t;

  state_t              state, state_nxt;
  logic [SLOT_W-1:0]   slot, slot_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                frame_entry;

  logic [VW-1:0]       active_reg, active_nxt;
  logic [VW-1:0]       pending_reg, pending_nxt;
  logic                pending_valid, pending_valid_nxt;

  logic [3:0]          digit_code_q, digit_code_nxt;
  logic [N_DIGITS-1:0] an_q, an_nxt;
  logic                frame_start_q;
  logic [N_DIGITS-1:0] suppress;
  logic                zero_run;

  assign bus.digit_code  = digit_code_q;
  assign bus.an          = an_q;
  assign bus.frame_start = frame_start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OFF;
    end else begin
      state <= state_nxt;
    end
  end

  // enable is checked before the slot walk so dropping it always wins
  always_comb begin
    state_nxt   = state;
    slot_nxt    = slot;
    cnt_nxt     = cnt;
    frame_entry = 1'b0;
    if (!bus.enable) begin
      state_nxt = OFF;
      slot_nxt  = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        OFF: begin
          state_nxt   = BLANK;
          slot_nxt    = '0;
          cnt_nxt     = '0;
          frame_entry = 1'b1;
        end
        BLANK: begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == BLANK_LAST) state_nxt = SHOW;
        end
        SHOW: begin
          if (cnt == SLOT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = BLANK;
            if (slot == DIGIT_LAST) begin
              slot_nxt    = '0;
              frame_entry = 1'b1;
            end else begin
              slot_nxt = slot + 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = OFF;
          slot_nxt  = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // A load on the frame-entry edge overwrites pending after the old value has moved to active
  always_comb begin
    active_nxt        = active_reg;
    pending_nxt       = pending_reg;
    pending_valid_nxt = pending_valid;
    if (frame_entry && pending_valid) begin
      active_nxt        = pending_reg;
      pending_valid_nxt = 1'b0;
    end
    if (bus.load) begin
      pending_nxt       = bus.value;
      pending_valid_nxt = 1'b1;
    end
  end

  always_comb begin
    zero_run = 1'b1;
    suppress = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run    = zero_run & (active_nxt[4*i +: 4] == 4'h0);
      suppress[i] = bus.lz_en && (i != 0) && zero_run;
    end
  end

  always_comb begin
    digit_code_nxt = digit_code_q;
    an_nxt         = '1;
    if (state_nxt == BLANK) digit_code_nxt = 4'(active_nxt >> (4 * slot_nxt));
    if (state_nxt == SHOW && !suppress[slot_nxt]) an_nxt = ~(N_DIGITS'(1) << slot_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot          <= '0;
      cnt           <= '0;
      active_reg    <= '0;
      pending_reg   <= '0;
      pending_valid <= 1'b0;
      digit_code_q  <= 4'h0;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      slot          <= slot_nxt;
      cnt           <= cnt_nxt;
      active_reg    <= active_nxt;
      pending_reg   <= pending_nxt;
      pending_valid <= pending_valid_nxt;
      digit_code_q  <= digit_code_nxt;
      an_q          <= an_nxt;
      frame_start_q <= frame_entry;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench: a frame-time reference model pushes expected pin states per clock,
// a negedge monitor pops and compares, plus no-overlap and blanking-gap checks.
module tb_seg7_scan_ctrl;
  localparam int N     = 4;
  localparam int R     = 8;
  localparam int B     = 2;
  localparam int FRAME = N * R;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] dc;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  seg7_scan_ctrl_if #(.N_DIGITS(N)) bus();

  seg7_scan_ctrl #(
    .N_DIGITS    (N),
    .REFRESH_DIV (R),
    .BLANK_CYCLES(B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: position in the frame is plain elapsed time since the display came on
  exp_t        exp_q[$];
  bit          m_on;
  int unsigned m_t;
  logic [15:0] m_active, m_pending;
  bit          m_pv;
  logic [3:0]  m_dc;

  always @(posedge rst) exp_q.delete();

  always @(posedge clk) begin
    exp_t e;
    int   slot, ph;
    e.an = 4'hF;
    e.fs = 1'b0;
    if (rst) begin
      m_on = 0; m_t = 0; m_active = '0; m_pending = '0; m_pv = 0; m_dc = 4'h0;
    end else begin
      if (!bus.enable) begin
        m_on = 0;
      end else begin
        if (!m_on) begin
          m_on = 1;
          m_t  = 0;
        end else begin
          m_t = (m_t + 1) % FRAME;
        end
        if (m_t == 0) begin
          e.fs = 1'b1;
          if (m_pv) begin
            m_active = m_pending;
            m_pv     = 0;
          end
        end
        slot = int'(m_t) / R;
        ph   = int'(m_t) % R;
        m_dc = m_active[4*slot +: 4];
        if (ph >= B && !(bus.lz_en && slot != 0 && (m_active >> (4*slot)) == 16'h0))
          e.an = ~(4'b0001 << slot);
      end
      if (bus.load) begin
        m_pending = bus.value;
        m_pv      = 1;
      end
    end
    e.dc = m_dc;
    exp_q.push_back(e);
  end

  // Monitor
  int last_lit = -1;
  int dark_run = 0;

  always @(negedge clk) begin
    exp_t e;
    int   lit_bits;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("an", 16'(bus.an), 16'(e.an));
      check("digit_code", 16'(bus.digit_code), 16'(e.dc));
      check("frame_start", 16'(bus.frame_start), 16'(e.fs));
    end
    lit_bits = $countones(~bus.an);
    checks++;
    if (lit_bits > 1) begin
      errors++;
      $display("FAIL overlap an=%b lit=%0d required<=1", bus.an, lit_bits);
    end
    if (lit_bits == 1) begin
      for (int d = 0; d < N; d++) begin
        if (!bus.an[d]) begin
          if (last_lit >= 0 && d != last_lit) begin
            checks++;
            if (dark_run < B) begin
              errors++;
              $display("FAIL blank_gap digit %0d->%0d dark=%0d required>=%0d", last_lit, d, dark_run, B);
            end
          end
          last_lit = d;
        end
      end
      dark_run = 0;
    end else begin
      dark_run++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.value = v;
    bus.load  = 1'b1;
    step(1);
    bus.load  = 1'b0;
  endtask

  task automatic wait_slot(input int s, input bit in_show, input bit at_start);
    int n = 0;
    while (!(m_on && int'(m_t) / R == s &&
             (in_show ? (int'(m_t) % R >= B) : 1'b1) &&
             (at_start ? (int'(m_t) % R == 0) : 1'b1)) && n < 200) begin
      step(1);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL wait_slot %0d timeout actual=%0d required<200 cycles", s, n);
    end
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v;
    v = 16'($urandom);
    for (int i = 0; i < 4; i++)
      if ($urandom_range(0, 1) == 0) v[4*i +: 4] = 4'h0;
    return v;
  endfunction

  initial begin
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.load   = 1'b0;
    bus.value  = '0;
    bus.lz_en  = 1'b0;
    #1;
    check("reset_an", 16'(bus.an), 16'hF);
    check("reset_dc", 16'(bus.digit_code), 16'h0);
    check("reset_fs", 16'(bus.frame_start), 16'h0);
    step(3);
    rst = 1'b0;
    step(2);

    // Basic scan of 1A3F
    do_load(16'h1A3F);
    step(2);
    bus.enable = 1'b1;
    step(2 * FRAME + 3);

    // Leading-zero suppression patterns
    bus.lz_en = 1'b1;
    do_load(16'h0005);
    step(2 * FRAME);
    do_load(16'h0000);
    step(2 * FRAME);
    do_load(16'h0100);
    step(2 * FRAME);
    bus.lz_en = 1'b0;
    do_load(16'h1A3F);
    step(FRAME + 4);

    // Late loads in one frame: only the last one reaches the display
    wait_slot(2, 0, 1);
    do_load(16'h1111);
    wait_slot(3, 0, 1);
    do_load(16'h2222);
    step(2 * FRAME);

    // Enable dropped mid-SHOW of slot 2, then restart
    wait_slot(2, 1, 0);
    bus.enable = 1'b0;
    step(4);
    bus.enable = 1'b1;
    step(FRAME + 2);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        bus.value = rand_value();
        bus.load  = 1'b1;
      end else begin
        bus.load  = 1'b0;
      end
      if ($urandom_range(0, 31) == 0) bus.lz_en = ~bus.lz_en;
      if ($urandom_range(0, 199) == 0) bus.enable = 1'b0;
      else if (!bus.enable && $urandom_range(0, 3) == 0) bus.enable = 1'b1;
      step(1);
    end
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    do_load(16'h9C07);
    step(FRAME + 2);

    // Asynchronous reset in the middle of a lit slot
    wait_slot(1, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_an", 16'(bus.an), 16'hF);
    check("async_rst_dc", 16'(bus.digit_code), 16'h0);
    check("async_rst_fs", 16'(bus.frame_start), 16'h0);
    step(3);
    bus.lz_en = 1'b1;
    rst = 1'b0;
    step(FRAME + 2);
    bus.lz_en = 1'b0;
    step(FRAME + 2);

    bus.enable = 1'b0;
    step(3);
    check("queue_drained", 16'(exp_q.size() <= 1), 16'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexes one hex-to-7-segment decoder across N_DIGITS common-anode digits.
- Each refresh slot drives one nibble of a 16-bit display value onto the shared decoder inputs and enables that digit's anode (active-low).
- Inserts a blanking gap at every digit switch to prevent ghosting; supports optional leading-zero suppression.
- Values load tear-free at frame boundaries. Sits between the system value source and the decoder/board pins.

Parameters:
- N_DIGITS, 4, number of digits; the display value is 4*N_DIGITS bits wide.
- REFRESH_DIV, 50000, clock cycles per digit slot (blank + show); must be ≥ 2.
- BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off; 1 ≤ BLANK_CYCLES < REFRESH_DIV.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- enable, in, 1, 1 = scanning runs; 0 = display dark.
- load, in, 1, 1-cycle strobe that captures `value` into the pending register.
- value, in, 4*N_DIGITS, hex digits; nibble 0 (LSBs) is digit 0, the rightmost.
- lz_en, in, 1, 1 = suppress leading zeros.
- digit_code, out, 4, nibble for the shared decoder (A = bit3 … D = bit0).
- an, out, N_DIGITS, anode enables, active-low, one-hot-low when lit.
- frame_start, out, 1, 1-cycle pulse on entry to slot 0.

Behaviour:
- Reset (async, rst=1):
  - an = all 1s; digit_code = 0; frame_start = 0.
  - state = OFF; slot = 0; cnt = 0.
  - active_reg = 0; pending_reg = 0; pending_valid = 0.
- Rst mid-scan forces these values immediately, without waiting for a clock edge.
- All outputs are registered.
- States:
  - OFF: an = all 1s; cnt = 0; slot = 0.
    - enable=1 → BLANK with slot 0 on the next edge; frame_start = 1 in that first BLANK cycle.
  - BLANK: an = all 1s; digit_code = nibble[slot] of active_reg; cnt increments.
    - cnt == BLANK_CYCLES-1 → SHOW.
  - SHOW: an[slot] = 0 and all other bits 1, unless the digit is suppressed (then an = all 1s).
    - cnt == REFRESH_DIV-1 → cnt = 0, slot = (slot+1) mod N_DIGITS, → BLANK.
- enable=0 in any state → OFF on the next edge. enable has priority over slot advance.
- Slot timing: exactly BLANK_CYCLES cycles dark, then REFRESH_DIV-BLANK_CYCLES cycles lit. A frame is N_DIGITS*REFRESH_DIV cycles.
- Wrap: slot N_DIGITS-1 → 0 re-enters BLANK. frame_start pulses in that first slot-0 BLANK cycle.
- Load:
  - load=1 → pending_reg = value; pending_valid = 1.
  - On each entry to slot 0 (from OFF or wrap) with pending_valid=1: active_reg = pending_reg; pending_valid = 0. The new digit_code reflects the new active_reg in that same cycle.
  - Multiple loads within a frame: the last one wins.
  - load coinciding with a slot-0 entry: the prior pending value transfers; the new value stays pending until the next frame.
- Leading-zero suppression: with lz_en=1, digit i (i ≥ 1) is suppressed when nibbles i … N_DIGITS-1 of active_reg are all 0. Digit 0 is never suppressed, so value 0 shows a single "0".
- lz_en is sampled combinationally per SHOW cycle; changes take effect on the next cycle.
- digit_code changes only on BLANK entry, so the decoder has BLANK_CYCLES to settle before the anode turns on.

Test Plan (N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset release, enable=1, load value=16'h1A3F before the first slot 0:
  - Cycle after enable: frame_start=1, an=4'b1111, digit_code=4'hF for 2 cycles.
  - Then an=4'b1110 for 6 cycles.
  - Then digit_code=3 with an=4'b1101, then A with 4'b1011, then 1 with 4'b0111.
  - Frame length 32 cycles; frame_start pulses every 32 cycles.
- lz_en=1, value=16'h0005: only digit 0 lights (an=4'b1110 in slot 0); slots 1–3 have an=4'b1111. value=16'h0000: digit 0 shows 0. value=16'h0100: digits 0–2 lit, digit 3 dark.
- Load 16'h1111 during slot 2, then 16'h2222 during slot 3: digits keep the old value until wrap. The next frame shows 2 on all digits; 1111 never appears.
- enable dropped mid-SHOW of slot 2: next edge an=4'b1111 and state OFF. Re-enable: restart at slot 0 with a frame_start pulse.
- rst asserted asynchronously mid-SHOW (between clock edges): an=4'b1111 and digit_code=0 immediately. After release with enable=1: active_reg=0, so the display shows 0000 (or a single 0 if lz_en=1).
- Check no overlap: across every slot transition, an is never 0 on two bits. There are at least 2 all-1s cycles between any two lit cycles of different digits.
